// File: rtl/sr_reg_bank.sv
// sr_reg_bank: bank of N independent, clocked SR channels with active-low requests.
//
// Parameters
//   N     number of channels (1..32)
//   MODE  action when both requests are active: 0 reset, 1 set, 2 hold, 3 toggle
//   CNTW  width of the saturating conflict-cycle counter (2..16)
//
// Ports
//   CLK       single clock, all state updates on the rising edge
//   RST       synchronous active-high reset
//   EN        update enable; low freezes Q, CONF and CONF_CNT
//   nS, nR    per-channel set / reset requests, active-low
//   CLR_CONF  clears sticky conflict flags and counter (independent of EN)
//   Q, nQ     registered channel state and its complement
//   CONF      sticky per-channel conflict flags
//   CONF_CNT  saturating count of cycles with at least one conflict
//   CHG       high for the cycle following an edge at which Q changed
module sr_reg_bank #(
    parameter int unsigned N    = 8,
    parameter int unsigned MODE = 0,
    parameter int unsigned CNTW = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic [N-1:0]    nS,
    input  logic [N-1:0]    nR,
    input  logic            CLR_CONF,
    output logic [N-1:0]    Q,
    output logic [N-1:0]    nQ,
    output logic [N-1:0]    CONF,
    output logic [CNTW-1:0] CONF_CNT,
    output logic            CHG
);

    localparam logic [CNTW-1:0] CntMax = {CNTW{1'b1}};

    logic [N-1:0]    q_d, q_q;
    logic [N-1:0]    conf_d, conf_q;
    logic [CNTW-1:0] cnt_d, cnt_q;
    logic            chg_d, chg_q;

    logic [N-1:0]    conflict;
    logic            any_conflict;

    // Only samples taken while enabled count as conflicts.
    assign conflict     = EN ? (~nS & ~nR) : '0;
    assign any_conflict = |conflict;

    always_comb begin
        q_d = q_q;
        if (EN) begin
            for (int i = 0; i < N; i++) begin
                unique case ({nS[i], nR[i]})
                    2'b11: q_d[i] = q_q[i];
                    2'b01: q_d[i] = 1'b1;
                    2'b10: q_d[i] = 1'b0;
                    default: begin
                        if (MODE == 0)      q_d[i] = 1'b0;
                        else if (MODE == 1) q_d[i] = 1'b1;
                        else if (MODE == 3) q_d[i] = ~q_q[i];
                        else                q_d[i] = q_q[i];
                    end
                endcase
            end
        end
    end

    // A conflict sampled on the clearing edge survives the clear.
    always_comb begin
        conf_d = (CLR_CONF ? '0 : conf_q) | conflict;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (CLR_CONF) begin
            cnt_d = any_conflict ? CNTW'(1) : '0;
        end else if (any_conflict && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_comb begin
        chg_d = (q_d != q_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q    <= '0;
            conf_q <= '0;
            cnt_q  <= '0;
            chg_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            conf_q <= conf_d;
            cnt_q  <= cnt_d;
            chg_q  <= chg_d;
        end
    end

    // Complement is derived from the single state register so Q and nQ can never agree.
    assign Q        = q_q;
    assign nQ       = ~q_q;
    assign CONF     = conf_q;
    assign CONF_CNT = cnt_q;
    assign CHG      = chg_q;

endmodule
